// File: rtl/cache_controller.sv
// cache_controller: direct-mapped read-only cache with 4-word blocks, fill from main_memory and hit/access counters
module cache_controller #(
    parameter int SETS        = 1024,
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [14:0] address,
    output logic        ready,
    output logic [31:0] data_out,
    output logic        hit,
    output logic        busy,
    output logic [14:0] mem_address,
    output logic        mem_hit,
    input  logic [31:0] mem_data1,
    input  logic [31:0] mem_data2,
    input  logic [31:0] mem_data3,
    input  logic [31:0] mem_data4,
    output logic [31:0] access_count,
    output logic [31:0] hit_count
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 13 - IW;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESPOND} state_t;

    state_t          state_q;
    logic [14:0]     addr_q;
    logic [3:0]      cnt_q;
    logic [SETS-1:0] valid_q;
    logic [TW-1:0]   tag_q [SETS];
    logic [31:0]     data_q [SETS][4];
    logic [31:0]     dout_q;
    logic            hit_q;
    logic            ready_q;
    logic            busy_q;
    logic            mem_hit_q;
    logic [31:0]     acc_q;
    logic [31:0]     hits_q;

    logic [IW-1:0] idx;
    logic [TW-1:0] tag_a;
    logic [1:0]    off;
    logic          lookup_hit;
    logic          fill_done;
    logic [31:0]   fill_word;

    assign idx        = addr_q[IW+1:2];
    assign tag_a      = addr_q[14:IW+2];
    assign off        = addr_q[1:0];
    assign lookup_hit = valid_q[idx] && tag_q[idx] == tag_a;
    assign fill_done  = state_q == FILL && cnt_q == 4'd0;
    assign fill_word  = off == 2'd0 ? mem_data1 :
                        off == 2'd1 ? mem_data2 :
                        off == 2'd2 ? mem_data3 : mem_data4;

    assign ready        = ready_q;
    assign data_out     = dout_q;
    assign hit          = hit_q;
    assign busy         = busy_q;
    assign mem_address  = {addr_q[14:2], 2'b00};
    assign mem_hit      = mem_hit_q;
    assign access_count = acc_q;
    assign hit_count    = hits_q;

    // Request sequencing, registered handshake outputs, valid bits and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            valid_q   <= '0;
            dout_q    <= '0;
            hit_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            mem_hit_q <= 1'b1;
            acc_q     <= '0;
            hits_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    addr_q  <= address;
                    busy_q  <= 1'b1;
                    state_q <= LOOKUP;
                end
                LOOKUP: if (lookup_hit) begin
                    dout_q  <= data_q[idx][off];
                    hit_q   <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= RESPOND;
                end else begin
                    cnt_q     <= 4'(MEM_LATENCY - 1);
                    mem_hit_q <= 1'b0;
                    state_q   <= FILL;
                end
                FILL: if (cnt_q == 4'd0) begin
                    valid_q[idx] <= 1'b1;
                    dout_q       <= fill_word;
                    hit_q        <= 1'b0;
                    ready_q      <= 1'b1;
                    mem_hit_q    <= 1'b1;
                    state_q      <= RESPOND;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    acc_q   <= acc_q + 32'd1;
                    hits_q  <= hits_q + {31'd0, hit_q};
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Block storage is written only on a completed fill; a reset on that edge drops the write
    always_ff @(posedge clk) begin
        if (!rst && fill_done) begin
            tag_q[idx]     <= tag_a;
            data_q[idx][0] <= mem_data1;
            data_q[idx][1] <= mem_data2;
            data_q[idx][2] <= mem_data3;
            data_q[idx][3] <= mem_data4;
        end
    end
endmodule
